// File: rtl/char_motion_ctrl_pkg.sv
// Shared character definitions: state encodings, facing encoding, arena geometry.
// Combinational constants only; no latency.
// No flow control; consumed by the state FSM, motion control and hitbox logic.
package char_pkg;

  // Character state encodings (shared with the per-character state FSM)
  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_LEFT        = 4'd1;
  localparam logic [3:0] ST_RIGHT       = 4'd2;
  localparam logic [3:0] ST_NATK_START  = 4'd3;
  localparam logic [3:0] ST_NATK_ACTIVE = 4'd4;
  localparam logic [3:0] ST_NATK_RECOV  = 4'd5;
  localparam logic [3:0] ST_DATK_START  = 4'd6;
  localparam logic [3:0] ST_DATK_ACTIVE = 4'd7;
  localparam logic [3:0] ST_DATK_RECOV  = 4'd8;

  // Facing encoding
  localparam logic FACE_RIGHT = 1'b0;
  localparam logic FACE_LEFT  = 1'b1;

  // Arena and body geometry (pixels)
  localparam int START_X        = 100;
  localparam int X_MIN          = 0;
  localparam int X_MAX          = 640;
  localparam int CHAR_W         = 64;
  localparam int STEP_FWD       = 3;
  localparam int STEP_BACK      = 2;
  localparam int HITBOX_LEN     = 32;
  localparam int DIR_HITBOX_LEN = 48;

  // Signed working width for the position update
  typedef logic signed [10:0] sx_t;

  typedef enum logic {LATCH_ARMED, LATCH_SPENT} latch_e;

  function automatic logic is_active_attack(input logic [3:0] st);
    return (st == ST_NATK_ACTIVE) || (st == ST_DATK_ACTIVE);
  endfunction

endpackage

// File: rtl/char_motion_ctrl_if.sv
// Per-frame character control bus: tick/state/facing/opponent in, position/hitbox/hit out.
// Pure signal bundle; no latency.
// No backpressure: all updates are paced by FRAME_TICK.
interface char_motion_ctrl_if;
  logic       FRAME_TICK;
  logic [3:0] STATE;
  logic       FACING;
  logic [9:0] OPP_X;
  logic [9:0] POS_X;
  logic       HITBOX_ACTIVE;
  logic [9:0] HITBOX_MIN;
  logic [9:0] HITBOX_MAX;
  logic       HIT_PULSE;
  logic [2:0] HITS_LANDED;

  // master: the upstream FSM / frame source; slave: the motion controller
  modport master (
    output FRAME_TICK, STATE, FACING, OPP_X,
    input  POS_X, HITBOX_ACTIVE, HITBOX_MIN, HITBOX_MAX, HIT_PULSE, HITS_LANDED
  );
  modport slave (
    input  FRAME_TICK, STATE, FACING, OPP_X,
    output POS_X, HITBOX_ACTIVE, HITBOX_MIN, HITBOX_MAX, HIT_PULSE, HITS_LANDED
  );
endinterface

// File: rtl/char_motion_ctrl_hitbox_gen.sv
// Attack hitbox bounds, validity and overlap against the opponent hurtbox.
// Purely combinational; zero latency.
// No flow control. Ports: pos_x, facing, state, opp_x in; hb_min/hb_max/hb_vld/hb_overlap out.
module char_hitbox_gen
  import char_pkg::*;
(
  input  logic [9:0] pos_x,
  input  logic       facing,
  input  logic [3:0] state,
  input  logic [9:0] opp_x,
  output logic [9:0] hb_min,
  output logic [9:0] hb_max,
  output logic       hb_vld,
  output logic       hb_overlap
);
  logic [10:0] len;
  logic [10:0] near_edge;
  logic [10:0] far_edge;
  logic [10:0] opp_end;

  always_comb begin
    hb_vld    = is_active_attack(state);
    len       = (state == ST_DATK_ACTIVE) ? 11'(DIR_HITBOX_LEN) : 11'(HITBOX_LEN);
    near_edge = {1'b0, pos_x} + 11'(CHAR_W);
    far_edge  = near_edge + len;
    hb_min    = '0;
    hb_max    = '0;
    if (hb_vld) begin
      if (facing == FACE_RIGHT) begin
        hb_min = (near_edge > 11'd1023) ? 10'd1023 : 10'(near_edge);
        hb_max = (far_edge > 11'd1023) ? 10'd1023 : 10'(far_edge);
      end else begin
        hb_min = ({1'b0, pos_x} >= len) ? 10'({1'b0, pos_x} - len) : 10'd0;
        hb_max = pos_x;
      end
    end
    // Half-open intervals: touching edges do not count as contact
    opp_end    = {1'b0, opp_x} + 11'(CHAR_W);
    hb_overlap = hb_vld && ({1'b0, hb_min} < opp_end) && (opp_x < hb_max);
  end
endmodule

// File: rtl/char_motion_ctrl.sv
// Per-frame character position, attack hitbox and one-shot hit event (macro CHAR_PUSHBOX_EN adds body blocking).
// 1 CLOCK latency: outputs register on the edge ending the FRAME_TICK cycle; HIT_PULSE lasts one CLOCK.
// No backpressure; inputs are sampled only on FRAME_TICK. Ports: CLOCK, RESET, bus (slave modport).
module char_motion_ctrl
  import char_pkg::*;
(
  input  logic                 CLOCK,
  input  logic                 RESET,
  char_motion_ctrl_if.slave    bus
);
  logic [9:0] pos_q, pos_d;
  logic       hb_act_q;
  logic [9:0] hb_min_q, hb_max_q;
  logic       hit_q;
  logic [2:0] hits_q;
  latch_e     latch_q, latch_d;
  logic       hit_fire;

  logic [9:0] hb_min, hb_max;
  logic       hb_vld, hb_overlap;

  // Hitbox uses the pre-update position; position never changes in attack states anyway
  char_hitbox_gen u_hitbox (
    .pos_x      (pos_q),
    .facing     (bus.FACING),
    .state      (bus.STATE),
    .opp_x      (bus.OPP_X),
    .hb_min     (hb_min),
    .hb_max     (hb_max),
    .hb_vld     (hb_vld),
    .hb_overlap (hb_overlap)
  );

  // Position update
  logic mv_left, mv_right, fwd;
  sx_t  cur, step, nxt;
`ifdef CHAR_PUSHBOX_EN
  sx_t  opp, lim;
`endif

  always_comb begin
    mv_left  = (bus.STATE == ST_LEFT);
    mv_right = (bus.STATE == ST_RIGHT);
    fwd      = (mv_left && bus.FACING == FACE_LEFT) || (mv_right && bus.FACING == FACE_RIGHT);
    step     = fwd ? sx_t'(STEP_FWD) : sx_t'(STEP_BACK);
    cur      = $signed({1'b0, pos_q});
    nxt      = cur;
    if (mv_right)     nxt = cur + step;
    else if (mv_left) nxt = cur - step;
`ifdef CHAR_PUSHBOX_EN
    opp = $signed({1'b0, bus.OPP_X});
    lim = cur;
    // Limit is never allowed to pull the body backwards: already overlapping means zero advance
    if (mv_right && opp > cur) begin
      lim = opp - sx_t'(CHAR_W);
      if (lim < cur) lim = cur;
      if (nxt > lim) nxt = lim;
    end else if (mv_left && opp < cur) begin
      lim = opp + sx_t'(CHAR_W);
      if (lim > cur) lim = cur;
      if (nxt < lim) nxt = lim;
    end
`endif
    if (nxt < sx_t'(X_MIN))          nxt = sx_t'(X_MIN);
    if (nxt > sx_t'(X_MAX - CHAR_W)) nxt = sx_t'(X_MAX - CHAR_W);
    pos_d = 10'(nxt);
  end

  // Hit latch: one connection per attack, re-armed by any tick outside an active phase
  always_comb begin
    latch_d  = latch_q;
    hit_fire = 1'b0;
    if (bus.FRAME_TICK) begin
      case (latch_q)
        LATCH_ARMED: if (hb_overlap) begin
          latch_d  = LATCH_SPENT;
          hit_fire = 1'b1;
        end
        LATCH_SPENT: if (!is_active_attack(bus.STATE)) latch_d = LATCH_ARMED;
        default:     latch_d = LATCH_ARMED;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pos_q    <= 10'(START_X);
      hb_act_q <= 1'b0;
      hb_min_q <= '0;
      hb_max_q <= '0;
      hit_q    <= 1'b0;
      hits_q   <= '0;
      latch_q  <= LATCH_ARMED;
    end else begin
      hit_q   <= hit_fire;
      latch_q <= latch_d;
      if (bus.FRAME_TICK) begin
        pos_q    <= pos_d;
        hb_act_q <= hb_vld;
        hb_min_q <= hb_min;
        hb_max_q <= hb_max;
        if (hit_fire && hits_q != 3'd7) hits_q <= hits_q + 3'd1;
      end
    end
  end

  assign bus.POS_X         = pos_q;
  assign bus.HITBOX_ACTIVE = hb_act_q;
  assign bus.HITBOX_MIN    = hb_min_q;
  assign bus.HITBOX_MAX    = hb_max_q;
  assign bus.HIT_PULSE     = hit_q;
  assign bus.HITS_LANDED   = hits_q;
endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed self-checking bench for char_motion_ctrl.
// Drives one tick at a time; samples outputs 1 time unit after the clock edge.
// Expected values are hand-computed from the character geometry.
module tb_char_motion_ctrl;
  logic CLOCK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK = ~CLOCK;

  char_motion_ctrl_if bus();

  char_motion_ctrl dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic tick(input logic [3:0] st);
    bus.STATE      = st;
    bus.FRAME_TICK = 1'b1;
    @(posedge CLOCK);
    #1;
    bus.FRAME_TICK = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.POS_X !== 10'd100) begin errors++; $display("FAIL reset_pos: got %0d want 100", bus.POS_X); end
    checks++; if (bus.HITBOX_ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.HITBOX_ACTIVE); end
    checks++; if (bus.HITBOX_MIN !== 10'd0 || bus.HITBOX_MAX !== 10'd0) begin errors++; $display("FAIL reset_hitbox: got [%0d,%0d) want [0,0)", bus.HITBOX_MIN, bus.HITBOX_MAX); end
    checks++; if (bus.HIT_PULSE !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.HIT_PULSE); end
    checks++; if (bus.HITS_LANDED !== 3'd0) begin errors++; $display("FAIL reset_hits: got %0d want 0", bus.HITS_LANDED); end
  endtask

  task automatic test_move();
    do_reset();
    bus.FACING = 1'b0; bus.OPP_X = 10'd400;
    tick(4'd2);
    checks++; if (bus.POS_X !== 10'd103) begin errors++; $display("FAIL move_first_tick: got %0d want 103", bus.POS_X); end
    for (int i = 0; i < 9; i++) tick(4'd2);
    checks++; if (bus.POS_X !== 10'd130) begin errors++; $display("FAIL move_fwd: got %0d want 130", bus.POS_X); end
    for (int i = 0; i < 5; i++) tick(4'd1);
    checks++; if (bus.POS_X !== 10'd120) begin errors++; $display("FAIL move_back: got %0d want 120", bus.POS_X); end
    // STATE changes without a tick must not move the character
    bus.STATE = 4'd2; idle_cycle(); bus.STATE = 4'd1; idle_cycle(); idle_cycle();
    checks++; if (bus.POS_X !== 10'd120) begin errors++; $display("FAIL hold_no_tick: got %0d want 120", bus.POS_X); end
    tick(4'd3);
    checks++; if (bus.POS_X !== 10'd120) begin errors++; $display("FAIL hold_attack_state: got %0d want 120", bus.POS_X); end
  endtask

  task automatic test_pushbox();
    logic [9:0] exp;
`ifdef CHAR_PUSHBOX_EN
    exp = 10'd116;
`else
    exp = 10'd130;
`endif
    do_reset();
    bus.FACING = 1'b0; bus.OPP_X = 10'd180;
    for (int i = 0; i < 10; i++) tick(4'd2);
    checks++; if (bus.POS_X !== exp) begin errors++; $display("FAIL pushbox: got %0d want %0d", bus.POS_X, exp); end
  endtask

  task automatic test_arena();
    logic [9:0] exp_seq [3];
    exp_seq[0] = 10'd2; exp_seq[1] = 10'd0; exp_seq[2] = 10'd0;
    do_reset();
    bus.FACING = 1'b0; bus.OPP_X = 10'd400;
    for (int i = 0; i < 48; i++) tick(4'd1);
    checks++; if (bus.POS_X !== 10'd4) begin errors++; $display("FAIL arena_reach4: got %0d want 4", bus.POS_X); end
    for (int i = 0; i < 3; i++) begin
      tick(4'd1);
      checks++; if (bus.POS_X !== exp_seq[i]) begin errors++; $display("FAIL arena_left_clamp%0d: got %0d want %0d", i, bus.POS_X, exp_seq[i]); end
    end
    bus.OPP_X = 10'd0; bus.FACING = 1'b1;
    for (int i = 0; i < 287; i++) tick(4'd2);
    checks++; if (bus.POS_X !== 10'd574) begin errors++; $display("FAIL arena_reach574: got %0d want 574", bus.POS_X); end
    bus.FACING = 1'b0;
    tick(4'd2);
    checks++; if (bus.POS_X !== 10'd576) begin errors++; $display("FAIL arena_right_clamp: got %0d want 576", bus.POS_X); end
    tick(4'd2);
    checks++; if (bus.POS_X !== 10'd576) begin errors++; $display("FAIL arena_right_hold: got %0d want 576", bus.POS_X); end
  endtask

  task automatic test_attack();
    do_reset();
    bus.FACING = 1'b0; bus.OPP_X = 10'd180;
    tick(4'd4);
    checks++; if (bus.HITBOX_ACTIVE !== 1'b1) begin errors++; $display("FAIL atk_active: got %b want 1", bus.HITBOX_ACTIVE); end
    checks++; if (bus.HITBOX_MIN !== 10'd164 || bus.HITBOX_MAX !== 10'd196) begin errors++; $display("FAIL atk_bounds: got [%0d,%0d) want [164,196)", bus.HITBOX_MIN, bus.HITBOX_MAX); end
    checks++; if (bus.HIT_PULSE !== 1'b1) begin errors++; $display("FAIL atk_pulse: got %b want 1", bus.HIT_PULSE); end
    checks++; if (bus.HITS_LANDED !== 3'd1) begin errors++; $display("FAIL atk_count1: got %0d want 1", bus.HITS_LANDED); end
    idle_cycle();
    checks++; if (bus.HIT_PULSE !== 1'b0) begin errors++; $display("FAIL atk_pulse_width: got %b want 0", bus.HIT_PULSE); end
    checks++; if (bus.HITBOX_ACTIVE !== 1'b1) begin errors++; $display("FAIL atk_active_hold: got %b want 1", bus.HITBOX_ACTIVE); end
    tick(4'd4);
    checks++; if (bus.HIT_PULSE !== 1'b0 || bus.HITS_LANDED !== 3'd1) begin errors++; $display("FAIL atk_one_shot: got pulse %b count %0d want 0/1", bus.HIT_PULSE, bus.HITS_LANDED); end
    tick(4'd5);
    checks++; if (bus.HITBOX_ACTIVE !== 1'b0) begin errors++; $display("FAIL atk_recovery_inactive: got %b want 0", bus.HITBOX_ACTIVE); end
    tick(4'd4);
    checks++; if (bus.HIT_PULSE !== 1'b1 || bus.HITS_LANDED !== 3'd2) begin errors++; $display("FAIL atk_rearm: got pulse %b count %0d want 1/2", bus.HIT_PULSE, bus.HITS_LANDED); end
  endtask

  task automatic test_dir_attack();
    bus.FACING = 1'b0; bus.OPP_X = 10'd200;
    tick(4'd5);
    tick(4'd4);
    checks++; if (bus.HIT_PULSE !== 1'b0 || bus.HITS_LANDED !== 3'd2) begin errors++; $display("FAIL natk_miss: got pulse %b count %0d want 0/2", bus.HIT_PULSE, bus.HITS_LANDED); end
    tick(4'd8);
    tick(4'd7);
    checks++; if (bus.HITBOX_MIN !== 10'd164 || bus.HITBOX_MAX !== 10'd212) begin errors++; $display("FAIL datk_bounds: got [%0d,%0d) want [164,212)", bus.HITBOX_MIN, bus.HITBOX_MAX); end
    checks++; if (bus.HIT_PULSE !== 1'b1 || bus.HITS_LANDED !== 3'd3) begin errors++; $display("FAIL datk_hit: got pulse %b count %0d want 1/3", bus.HIT_PULSE, bus.HITS_LANDED); end
  endtask

  task automatic test_facing_left();
    bus.FACING = 1'b1; bus.OPP_X = 10'd10;
    tick(4'd0);
    tick(4'd4);
    checks++; if (bus.HITBOX_MIN !== 10'd68 || bus.HITBOX_MAX !== 10'd100) begin errors++; $display("FAIL left_bounds: got [%0d,%0d) want [68,100)", bus.HITBOX_MIN, bus.HITBOX_MAX); end
    checks++; if (bus.HIT_PULSE !== 1'b1 || bus.HITS_LANDED !== 3'd4) begin errors++; $display("FAIL left_hit: got pulse %b count %0d want 1/4", bus.HIT_PULSE, bus.HITS_LANDED); end
    tick(4'd5);
    tick(4'd7);
    checks++; if (bus.HITBOX_MIN !== 10'd52 || bus.HITBOX_MAX !== 10'd100) begin errors++; $display("FAIL left_dir_bounds: got [%0d,%0d) want [52,100)", bus.HITBOX_MIN, bus.HITBOX_MAX); end
  endtask

  task automatic test_saturate();
    // count is 5 here; two more hits reach 7, a third must pulse without counting
    for (int i = 0; i < 2; i++) begin tick(4'd5); tick(4'd4); end
    checks++; if (bus.HITS_LANDED !== 3'd7) begin errors++; $display("FAIL sat_reach7: got %0d want 7", bus.HITS_LANDED); end
    tick(4'd5);
    tick(4'd4);
    checks++; if (bus.HIT_PULSE !== 1'b1 || bus.HITS_LANDED !== 3'd7) begin errors++; $display("FAIL sat_hold: got pulse %b count %0d want 1/7", bus.HIT_PULSE, bus.HITS_LANDED); end
  endtask

  task automatic test_reset_mid_attack();
    bus.FACING = 1'b0; bus.OPP_X = 10'd200;
    tick(4'd1); tick(4'd1);
    checks++; if (bus.POS_X !== 10'd96) begin errors++; $display("FAIL pre_reset_pos: got %0d want 96", bus.POS_X); end
    tick(4'd7);
    checks++; if (bus.HIT_PULSE !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %b want 1", bus.HIT_PULSE); end
    // reset coincides with a tick in the active phase while the latch is spent
    bus.STATE = 4'd7; bus.FRAME_TICK = 1'b1; RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0; bus.FRAME_TICK = 1'b0;
    checks++; if (bus.POS_X !== 10'd100 || bus.HITBOX_ACTIVE !== 1'b0 || bus.HITS_LANDED !== 3'd0 || bus.HIT_PULSE !== 1'b0) begin
      errors++; $display("FAIL reset_mid_attack: got pos %0d act %b hits %0d pulse %b want 100/0/0/0", bus.POS_X, bus.HITBOX_ACTIVE, bus.HITS_LANDED, bus.HIT_PULSE);
    end
    tick(4'd7);
    checks++; if (bus.HIT_PULSE !== 1'b1 || bus.HITS_LANDED !== 3'd1 || bus.HITBOX_ACTIVE !== 1'b1) begin
      errors++; $display("FAIL post_reset_hit: got pulse %b hits %0d act %b want 1/1/1", bus.HIT_PULSE, bus.HITS_LANDED, bus.HITBOX_ACTIVE);
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.FRAME_TICK = 1'b0;
    bus.STATE      = 4'd0;
    bus.FACING     = 1'b0;
    bus.OPP_X      = 10'd400;
    repeat (2) @(posedge CLOCK);
    #1;
    test_reset();
    test_move();
    test_pushbox();
    test_arena();
    test_attack();
    test_dir_attack();
    test_facing_left();
    test_saturate();
    test_reset_mid_attack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_motion_ctrl.md
# char_motion_ctrl

Downstream consumer of the per-character state FSM. Once per video frame it turns the 4-bit character state into a horizontal position, an attack hitbox and a one-shot hit event against the opponent. Its outputs drive the sprite renderer and the health/score logic.

## Interface
- START_X, 100: POS_X value after reset.
- X_MIN, 0: left arena bound (pixels).
- X_MAX, 640: right arena bound; the character occupies [POS_X, POS_X+CHAR_W).
- CHAR_W, 64: body/hurtbox width.
- STEP_FWD, 3: pixels per frame when moving toward the facing direction.
- STEP_BACK, 2: pixels per frame when moving away from the facing direction.
- HITBOX_LEN, 32: hitbox reach for the neutral attack.
- DIR_HITBOX_LEN, 48: hitbox reach for the directional attack.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  one clock; reset is synchronous and active-high.
- FRAME_TICK  in  1  one-CLOCK pulse per video frame. All updates happen only on this pulse.
- STATE  in  4  character state: 0 idle, 1 left, 2 right, 3/4/5 neutral attack start/active/recovery, 6/7/8 directional attack start/active/recovery.
- FACING  in  1  0 = faces right, 1 = faces left.
- OPP_X  in  10  opponent POS_X.
- POS_X  out  10  character left edge.
- HITBOX_ACTIVE  out  1  hitbox live this frame.
- HITBOX_MIN / HITBOX_MAX  out  10 each  hitbox as a half-open interval [MIN, MAX).
- HIT_PULSE  out  1  one-CLOCK pulse when an attack connects.
- HITS_LANDED  out  3  saturating count of connected attacks.

## Operation
- Movement applies only when FRAME_TICK=1 and STATE is 1 or 2.
  - STATE 1 moves left, STATE 2 moves right.
  - Step size is STEP_FWD if the move direction equals the facing direction, otherwise STEP_BACK.
  - Compute in 11-bit signed. Clamp to [X_MIN, X_MAX−CHAR_W].
- All other states hold POS_X. This includes attacks: no movement during any attack phase.
- Hitbox is valid only in STATE 4 (length HITBOX_LEN) or STATE 7 (length DIR_HITBOX_LEN).
  - FACING=0: [POS_X+CHAR_W, POS_X+CHAR_W+len).
  - FACING=1: [max(POS_X−len, 0), POS_X).
  - Saturate MAX at 1023.
- Overlap test against the opponent hurtbox [OPP_X, OPP_X+CHAR_W): hbMIN < OPP_X+CHAR_W and OPP_X < hbMAX.
- Hit latch FSM:
  - States: ARMED and SPENT.
  - ARMED → SPENT on a tick where the hitbox is valid and overlaps. HIT_PULSE fires on this transition and HITS_LANDED increments, saturating at 7.
  - SPENT → ARMED on any tick where STATE is not 4 and not 7.
  - Result: at most one hit per attack.
- STATE changes between ticks are ignored; STATE is sampled only at the tick.

## Timing
- Reset values: POS_X=START_X, HITBOX_ACTIVE=0, HITBOX_MIN=0, HITBOX_MAX=0, HIT_PULSE=0, HITS_LANDED=0, latch=ARMED.
- All outputs are registered. Values computed from the tick-cycle inputs appear on the CLOCK edge ending the tick cycle, i.e. 1-cycle latency.
- Hitbox uses the POS_X held before the tick's update. POS_X never changes in an attack state, so there is no ambiguity.
- HIT_PULSE is high for exactly one CLOCK and low on all non-tick cycles.
- Without a tick, every output holds its value, except HIT_PULSE, which returns to 0.
- RESET has priority over FRAME_TICK. Reset mid-attack clears the latch and the hitbox on the next edge.
- Boundaries:
  - POS_X at X_MIN with a left move: stays at X_MIN.
  - POS_X at X_MAX−CHAR_W with a right move: stays.
  - HITS_LANDED=7 plus a hit: HIT_PULSE still fires, count stays 7.

## Configuration
- Macro CHAR_PUSHBOX_EN.
- Defined: bodies cannot interpenetrate.
  - Moving right: the new POS_X is limited to OPP_X−CHAR_W when OPP_X > POS_X.
  - Moving left: the new POS_X is limited to OPP_X+CHAR_W when OPP_X < POS_X.
  - If the bodies already overlap, forward motion is 0.
  - The pushbox limit applies before the arena clamp.
- Undefined: only the arena clamp applies; characters may pass through each other.

## Structure
- Shared package char_pkg: the STATE encodings 0–8 as localparams (shared with the state FSM) and the FACING encoding.
- Sub-module char_hitbox_gen (combinational): takes POS_X, FACING, STATE; produces hitbox bounds, valid and overlap. The parent owns all registers, the position update and the hit latch.

## Test plan
- POS_X=100, FACING=0, OPP_X=400, STATE=2 for 10 ticks → POS_X=130. Then STATE=1 for 5 ticks → POS_X=120.
- CHAR_PUSHBOX_EN defined, POS_X=100, OPP_X=180, STATE=2 for 10 ticks → POS_X stops at 116. Undefined → POS_X=130.
- POS_X=4, FACING=0, STATE=1 for 3 ticks → 2, 0, 0. POS_X=574, STATE=2 → holds 576 (=X_MAX−CHAR_W).
- POS_X=100, FACING=0, OPP_X=180, STATE=4 for 2 ticks → HITBOX=[164,196), HIT_PULSE once, HITS_LANDED=1. A second 4-then-5-then-4 sequence → HITS_LANDED=2.
- OPP_X=200: STATE=4 → no hit, since [164,196) misses. STATE=7 → hit, since [164,212) overlaps.
- RESET asserted during STATE=7 with the latch SPENT → next edge: POS_X=100, HITBOX_ACTIVE=0, HITS_LANDED=0. The next STATE=7 tick with overlap produces HIT_PULSE.
